// File: rtl/iotdf_frame_sched_if.sv
// Bundle of the requester, filter and result signals around the frame scheduler.
// The master side is the environment (requesters and filter). The slave side is the scheduler.
interface iotdf_frame_sched_if #(
    parameter int NBYTES = 16
);
    // requester 0
    logic                  req0;
    logic [8*NBYTES-1:0]   frame0;
    logic [2:0]            fn0;
    logic                  ack0;
    // requester 1
    logic                  req1;
    logic [8*NBYTES-1:0]   frame1;
    logic [2:0]            fn1;
    logic                  ack1;
    // byte-serial feed into the filter
    logic                  flt_in_en;
    logic [7:0]            flt_iot_in;
    logic [2:0]            flt_fn_sel;
    logic                  flt_busy;
    // filter results
    logic                  flt_valid;
    logic [8*NBYTES-1:0]   flt_iot_out;
    // tagged results and status
    logic                  res_valid;
    logic                  res_src;
    logic [8*NBYTES-1:0]   res_data;
    logic                  err_orphan;
    logic                  idle;

    modport master (
        output req0, frame0, fn0, req1, frame1, fn1,
        output flt_busy, flt_valid, flt_iot_out,
        input  ack0, ack1, flt_in_en, flt_iot_in, flt_fn_sel,
        input  res_valid, res_src, res_data, err_orphan, idle
    );

    modport slave (
        input  req0, frame0, fn0, req1, frame1, fn1,
        input  flt_busy, flt_valid, flt_iot_out,
        output ack0, ack1, flt_in_en, flt_iot_in, flt_fn_sel,
        output res_valid, res_src, res_data, err_orphan, idle
    );
endinterface

// File: rtl/iotdf_frame_sched.sv
// Round-robin scheduler that shares one byte-serial IoT filter between two
// frame requesters. A granted frame is latched and then streamed MSB byte first.
// The requester id of each streamed frame is queued as a tag. Filter results are
// returned in order, so each result takes the oldest tag.
module iotdf_frame_sched #(
    parameter int TAG_DEPTH = 4,
    parameter int NBYTES    = 16
) (
    input  logic              clk,
    input  logic              rst,
    iotdf_frame_sched_if.slave bus
);
    localparam int FW = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam int AW = $clog2(TAG_DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);
    localparam logic [AW:0]   DEPTH    = (AW + 1)'(TAG_DEPTH);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t          state, state_nx;
    logic            rr;          // id of the last grant; the other side wins a tie
    logic [FW-1:0]   frame_q;
    logic [2:0]      fn_q;
    logic            id_q;
    logic [IW-1:0]   idx;

    logic            grant, grant_id, send, last;
    logic [FW-1:0]   frame_shift;
    logic [7:0]      cur_byte;

    // Tag FIFO. It holds one bit per frame that has been streamed but not yet answered.
    logic [TAG_DEPTH-1:0] tag_mem;
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 fifo_full, fifo_empty, push, pop;

    assign fifo_full  = (count == DEPTH);
    assign fifo_empty = (count == '0);
    assign push       = last;
    assign pop        = bus.flt_valid & ~fifo_empty;

    // Next state, arbitration and per-cycle byte send decision
    always_comb begin
        state_nx = state;
        grant    = 1'b0;
        grant_id = 1'b0;
        send     = 1'b0;
        last     = 1'b0;
        case (state)
            IDLE: begin
                // A full tag FIFO only holds off new grants.
                if ((bus.req0 | bus.req1) & ~fifo_full) begin
                    grant    = 1'b1;
                    grant_id = (bus.req0 & bus.req1) ? ~rr : bus.req1;
                    state_nx = STREAM;
                end
            end
            STREAM: begin
                if (!bus.flt_busy) begin
                    send = 1'b1;
                    if (idx == LAST_IDX) begin
                        last     = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // ack is high during the cycle whose closing edge latches the frame.
    // It is gated by reset so that a pending req cannot pulse ack while in reset.
    assign bus.ack0 = grant & ~grant_id & ~rst;
    assign bus.ack1 = grant &  grant_id & ~rst;

    assign bus.flt_fn_sel = fn_q;
    assign bus.idle       = (state == IDLE) & fifo_empty;

    // Select byte idx: shift it into the top byte of the frame
    assign frame_shift = frame_q << {idx, 3'b000};
    assign cur_byte    = frame_shift[FW-1 -: 8];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Grant latch, round-robin pointer and byte index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr      <= 1'b1;
            frame_q <= '0;
            fn_q    <= '0;
            id_q    <= 1'b0;
            idx     <= '0;
        end else if (grant) begin
            rr      <= grant_id;
            frame_q <= grant_id ? bus.frame1 : bus.frame0;
            fn_q    <= grant_id ? bus.fn1 : bus.fn0;
            id_q    <= grant_id;
            idx     <= '0;
        end else if (send) begin
            idx     <= idx + IW'(1);
        end
    end

    // Registered byte strobe. A stalled cycle drops the strobe and keeps the index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.flt_in_en  <= 1'b0;
            bus.flt_iot_in <= '0;
        end else begin
            bus.flt_in_en <= send;
            if (send) bus.flt_iot_in <= cur_byte;
        end
    end

    // Tag FIFO pointers and occupancy. A push and a pop in the same cycle leave count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                tag_mem[wr_ptr] <= id_q;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Tagged result strobe and the sticky orphan flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.res_valid  <= 1'b0;
            bus.res_src    <= 1'b0;
            bus.res_data   <= '0;
            bus.err_orphan <= 1'b0;
        end else begin
            bus.res_valid <= pop;
            if (pop) begin
                bus.res_src  <= tag_mem[rd_ptr];
                bus.res_data <= bus.flt_iot_out;
            end
            if (bus.flt_valid & fifo_empty) bus.err_orphan <= 1'b1;
        end
    end
endmodule

// File: tb/tb_iotdf_frame_sched.sv
// Bench for iotdf_frame_sched. Directed scenarios and a randomized soak run against a
// queue-based model of the scheduler, which is stepped once per clock.
module tb_iotdf_frame_sched;
    localparam int NB = 16;
    localparam int TD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iotdf_frame_sched_if #(.NBYTES(NB)) bus();
    iotdf_frame_sched #(.TAG_DEPTH(TD), .NBYTES(NB)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model state: bytes left in the current frame, the outstanding tag queue, and last grant
    int           m_left;
    logic [7:0]   m_bytes [NB];
    logic [2:0]   m_fn;
    logic         m_rr, m_id, m_err;
    logic         m_tags [$];
    logic         e_en, e_rv, e_src;
    logic [7:0]   e_byte;
    logic [127:0] e_data;

    // Observation logs
    logic         last_ack0, last_ack1;
    logic         ack_log [$];
    logic [7:0]   byte_log [$];
    int           runs [$];
    int           gaps [$];
    logic         rsrc_log [$];
    logic [127:0] rdat_log [$];
    logic         prev_en, have_run;
    int           run_cnt, gap_cnt;
    int           ab, bb, rb, runb, gapb;

    bit auto_flt = 0, auto_busy = 0, auto_req = 0;

    task automatic monitor();
        logic cg, gid, pushp;
        logic [127:0] f;
        if (rst) begin
            m_left = 0; m_tags.delete(); m_fn = 3'd0; m_rr = 1'b1; m_id = 1'b0; m_err = 1'b0;
            e_en = 1'b0; e_rv = 1'b0; last_ack0 = 1'b0; last_ack1 = 1'b0;
            prev_en = 1'b0; have_run = 1'b0; run_cnt = 0; gap_cnt = 0;
            return;
        end
        cg  = (m_left == 0) && (m_tags.size() < TD) && (bus.req0 || bus.req1);
        gid = (bus.req0 && bus.req1) ? ~m_rr : bus.req1;
        chk("ack0", 128'(bus.ack0), 128'(cg && !gid));
        chk("ack1", 128'(bus.ack1), 128'(cg && gid));
        chk("idle", 128'(bus.idle), 128'((m_left == 0) && (m_tags.size() == 0)));
        chk("in_en", 128'(bus.flt_in_en), 128'(e_en));
        if (e_en) chk("iot_in", 128'(bus.flt_iot_in), 128'(e_byte));
        chk("fn_sel", 128'(bus.flt_fn_sel), 128'(m_fn));
        chk("res_valid", 128'(bus.res_valid), 128'(e_rv));
        if (e_rv) begin
            chk("res_src", 128'(bus.res_src), 128'(e_src));
            chk("res_data", bus.res_data, e_data);
        end
        chk("err_orphan", 128'(bus.err_orphan), 128'(m_err));
        // logs
        last_ack0 = bus.ack0;
        last_ack1 = bus.ack1;
        if (bus.ack0) ack_log.push_back(1'b0);
        if (bus.ack1) ack_log.push_back(1'b1);
        if (bus.res_valid) begin
            rsrc_log.push_back(bus.res_src);
            rdat_log.push_back(bus.res_data);
        end
        if (bus.flt_in_en) begin
            byte_log.push_back(bus.flt_iot_in);
            if (!prev_en && have_run) gaps.push_back(gap_cnt);
            run_cnt++;
        end else begin
            if (prev_en) begin
                runs.push_back(run_cnt);
                have_run = 1'b1;
                run_cnt = 0;
                gap_cnt = 0;
            end
            gap_cnt++;
        end
        prev_en = bus.flt_in_en;
        // advance over the coming edge
        pushp = 1'b0;
        e_en  = 1'b0;
        if (m_left > 0 && !bus.flt_busy) begin
            e_en   = 1'b1;
            e_byte = m_bytes[NB - m_left];
            m_left--;
            if (m_left == 0) pushp = 1'b1;
        end
        e_rv = 1'b0;
        if (bus.flt_valid) begin
            if (m_tags.size() > 0) begin
                e_rv   = 1'b1;
                e_src  = m_tags.pop_front();
                e_data = bus.flt_iot_out;
            end else begin
                m_err = 1'b1;
            end
        end
        if (pushp) m_tags.push_back(m_id);
        if (cg) begin
            f = gid ? bus.frame1 : bus.frame0;
            for (int b = 0; b < NB; b++) m_bytes[b] = f[127 - 8*b -: 8];
            m_fn   = gid ? bus.fn1 : bus.fn0;
            m_rr   = gid;
            m_id   = gid;
            m_left = NB;
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One clock: check and advance the model at negedge, then drive auto stimulus 1 time unit after posedge
    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (auto_flt) begin
            if (m_tags.size() > 0 && $urandom_range(0, 2) == 0) begin
                bus.flt_valid = 1'b1;
                bus.flt_iot_out = rnd128();
            end else begin
                bus.flt_valid = 1'b0;
            end
        end
        if (auto_busy) bus.flt_busy = ($urandom_range(0, 4) == 0);
        if (auto_req) begin
            if (last_ack0) begin
                if ($urandom_range(0, 1) == 1) bus.req0 = 1'b0;
                else begin bus.frame0 = rnd128(); bus.fn0 = 3'($urandom); end
            end else if (!bus.req0) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.req0 = 1'b1; bus.frame0 = rnd128(); bus.fn0 = 3'($urandom);
                end
            end else if ($urandom_range(0, 19) == 0) bus.req0 = 1'b0;
            if (last_ack1) begin
                if ($urandom_range(0, 1) == 1) bus.req1 = 1'b0;
                else begin bus.frame1 = rnd128(); bus.fn1 = 3'($urandom); end
            end else if (!bus.req1) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.req1 = 1'b1; bus.frame1 = rnd128(); bus.fn1 = 3'($urandom);
                end
            end else if ($urandom_range(0, 19) == 0) bus.req1 = 1'b0;
        end
    endtask

    task automatic snap();
        ab = ack_log.size(); bb = byte_log.size(); rb = rsrc_log.size();
        runb = runs.size(); gapb = gaps.size();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [127:0] fb;
        bus.req0 = 1'b0; bus.frame0 = '0; bus.fn0 = 3'd0;
        bus.req1 = 1'b0; bus.frame1 = '0; bus.fn1 = 3'd0;
        bus.flt_busy = 1'b0; bus.flt_valid = 1'b0; bus.flt_iot_out = '0;

        // Reset state. A pending req must not raise ack while in reset.
        step();
        bus.req0 = 1'b1;
        #1;
        chk("rst_ack0", 128'(bus.ack0), 128'(0));
        chk("rst_ack1", 128'(bus.ack1), 128'(0));
        chk("rst_en", 128'(bus.flt_in_en), 128'(0));
        chk("rst_iot_in", 128'(bus.flt_iot_in), 128'(0));
        chk("rst_fn", 128'(bus.flt_fn_sel), 128'(0));
        chk("rst_rv", 128'(bus.res_valid), 128'(0));
        chk("rst_src", 128'(bus.res_src), 128'(0));
        chk("rst_data", bus.res_data, 128'(0));
        chk("rst_err", 128'(bus.err_orphan), 128'(0));
        chk("rst_idle", 128'(bus.idle), 128'(1));
        bus.req0 = 1'b0;
        step();
        rst = 1'b0;

        // Single frame
        bus.frame0 = 128'h8000_0000_0000_0000_0000_0000_0000_0000;
        bus.fn0 = 3'b001;
        bus.req0 = 1'b1;
        snap();
        for (int i = 0; i < 10 && ack_log.size() == ab; i++) step();
        bus.req0 = 1'b0;
        for (int i = 0; i < 22; i++) step();
        chk("t1_acks", 128'(ack_log.size() - ab), 128'(1));
        if (ack_log.size() > ab) chk("t1_ack_id", 128'(ack_log[ab]), 128'(0));
        chk("t1_nbytes", 128'(byte_log.size() - bb), 128'(NB));
        for (int i = 0; i < NB && bb + i < byte_log.size(); i++)
            chk("t1_byte", 128'(byte_log[bb + i]), (i == 0) ? 128'h80 : 128'h0);
        chk("t1_run", 128'(runs.size() > runb ? runs[runb] : 0), 128'(NB));
        chk("t1_fn", 128'(bus.flt_fn_sel), 128'(3'b001));
        bus.flt_valid = 1'b1;
        bus.flt_iot_out = '1;
        step();
        bus.flt_valid = 1'b0;
        step();
        chk("t1_nres", 128'(rsrc_log.size() - rb), 128'(1));
        if (rsrc_log.size() > rb) begin
            chk("t1_src", 128'(rsrc_log[rb]), 128'(0));
            chk("t1_data", rdat_log[rb], {128{1'b1}});
        end

        // Contention: both requesters held from reset
        rst = 1'b1;
        bus.req0 = 1'b1; bus.frame0 = rnd128(); bus.fn0 = 3'd2;
        bus.req1 = 1'b1; bus.frame1 = rnd128(); bus.fn1 = 3'd5;
        step();
        step();
        snap();
        rst = 1'b0;
        auto_flt = 1;
        for (int i = 0; i < 200 && ack_log.size() - ab < 4; i++) step();
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        for (int i = 0; i < 90; i++) step();
        auto_flt = 0;
        bus.flt_valid = 1'b0;
        chk("t2_acks", 128'(ack_log.size() - ab), 128'(4));
        for (int i = 0; i < 4 && ab + i < ack_log.size(); i++)
            chk("t2_ack_order", 128'(ack_log[ab + i]), 128'(i % 2));
        for (int i = 0; i < 4 && runb + i < runs.size(); i++)
            chk("t2_run", 128'(runs[runb + i]), 128'(NB));
        chk("t2_ngaps", 128'(gaps.size() - gapb), 128'(3));
        for (int i = 0; i < 3 && gapb + i < gaps.size(); i++)
            chk("t2_gap", 128'(gaps[gapb + i]), 128'(1));
        chk("t2_nres", 128'(rsrc_log.size() - rb), 128'(4));
        for (int i = 0; i < 4 && rb + i < rsrc_log.size(); i++)
            chk("t2_src_order", 128'(rsrc_log[rb + i]), 128'(i % 2));

        // Busy stall after byte 5
        do_reset();
        bus.frame0 = 128'h000102030405060708090A0B0C0D0E0F;
        bus.fn0 = 3'd6;
        bus.req0 = 1'b1;
        snap();
        for (int i = 0; i < 10 && ack_log.size() == ab; i++) step();
        bus.req0 = 1'b0;
        for (int i = 0; i < 30 && !(bus.flt_in_en && bus.flt_iot_in == 8'h05); i++) step();
        bus.flt_busy = 1'b1;
        step(); step(); step();
        bus.flt_busy = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("t3_nbytes", 128'(byte_log.size() - bb), 128'(NB));
        for (int i = 0; i < NB && bb + i < byte_log.size(); i++)
            chk("t3_byte", 128'(byte_log[bb + i]), 128'(i));
        chk("t3_nruns", 128'(runs.size() - runb), 128'(2));
        if (runs.size() - runb == 2) begin
            chk("t3_run0", 128'(runs[runb]), 128'(6));
            chk("t3_run1", 128'(runs[runb + 1]), 128'(10));
        end
        if (gaps.size() > gapb) chk("t3_stall", 128'(gaps[gapb]), 128'(3));

        // Tag FIFO full: filter silent, req1 held
        do_reset();
        bus.req1 = 1'b1;
        bus.frame1 = rnd128();
        bus.fn1 = 3'd3;
        snap();
        for (int i = 0; i < 120; i++) step();
        chk("t4_acks_full", 128'(ack_log.size() - ab), 128'(4));
        chk("t4_idle", 128'(bus.idle), 128'(0));
        for (int i = 0; i < 30; i++) step();
        chk("t4_starve", 128'(ack_log.size() - ab), 128'(4));
        bus.flt_valid = 1'b1;
        bus.flt_iot_out = rnd128();
        step();
        bus.flt_valid = 1'b0;
        for (int i = 0; i < 30 && ack_log.size() - ab < 5; i++) step();
        bus.req1 = 1'b0;
        step();
        chk("t4_acks_rel", 128'(ack_log.size() - ab), 128'(5));
        chk("t4_nres", 128'(rsrc_log.size() - rb), 128'(1));
        if (rsrc_log.size() > rb) chk("t4_src", 128'(rsrc_log[rb]), 128'(1));

        // Orphan result
        do_reset();
        snap();
        bus.flt_valid = 1'b1;
        bus.flt_iot_out = rnd128();
        step();
        bus.flt_valid = 1'b0;
        step();
        step();
        chk("t5_nres", 128'(rsrc_log.size() - rb), 128'(0));
        chk("t5_err", 128'(bus.err_orphan), 128'(1));
        for (int i = 0; i < 10; i++) step();
        chk("t5_err_sticky", 128'(bus.err_orphan), 128'(1));
        do_reset();
        chk("t5_err_clr", 128'(bus.err_orphan), 128'(0));

        // Reset at byte 8, then a clean restart from byte 0
        do_reset();
        bus.frame0 = rnd128();
        bus.fn0 = 3'd4;
        bus.req0 = 1'b1;
        snap();
        for (int i = 0; i < 10 && ack_log.size() == ab; i++) step();
        bus.req0 = 1'b0;
        for (int i = 0; i < 30 && !(bus.flt_in_en && byte_log.size() - bb == 8); i++) step();
        chk("t6_at_byte8", 128'(bus.flt_in_en), 128'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_en", 128'(bus.flt_in_en), 128'(0));
        step();
        step();
        rst = 1'b0;
        #1;
        chk("t6_idle", 128'(bus.idle), 128'(1));
        fb = rnd128();
        bus.frame0 = fb;
        bus.req0 = 1'b1;
        snap();
        for (int i = 0; i < 10 && ack_log.size() == ab; i++) step();
        bus.req0 = 1'b0;
        for (int i = 0; i < 25; i++) step();
        chk("t6_nbytes", 128'(byte_log.size() - bb), 128'(NB));
        for (int i = 0; i < NB && bb + i < byte_log.size(); i++)
            chk("t6_byte", 128'(byte_log[bb + i]), 128'(fb[127 - 8*i -: 8]));

        // Randomized soak against the model, then drain
        do_reset();
        snap();
        auto_flt = 1; auto_busy = 1; auto_req = 1;
        for (int i = 0; i < 1500; i++) step();
        auto_req = 0; auto_busy = 0;
        bus.req0 = 1'b0; bus.req1 = 1'b0; bus.flt_busy = 1'b0;
        for (int i = 0; i < 120; i++) step();
        auto_flt = 0;
        bus.flt_valid = 1'b0;
        step();
        chk("t7_drained", 128'(bus.idle), 128'(1));
        chk("t7_res_vs_acks", 128'(rsrc_log.size() - rb), 128'(ack_log.size() - ab));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/iotdf_frame_sched.md
Name: iotdf_frame_sched

Overview:
- Round-robin scheduler that shares one IoT data-filter datapath (byte-serial in, 128-bit result out) between two frame requesters.
- Latches a granted 128-bit frame plus its function select, streams it MSB byte first into the filter, and tags each filter result with its source.
- Sits between the sensor-side frame producers and the filter instance.

Parameters:
- TAG_DEPTH, 4, maximum outstanding frames streamed but not yet answered by the filter (power of 2, >=2).
- NBYTES, 16, bytes per frame; the frame width is 8*NBYTES.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0  in  1  requester 0 has a frame ready; held until ack0.
- frame0  in  128  requester 0 frame; byte 0 = [127:120].
- fn0  in  3  requester 0 function select.
- ack0  out  1  one-cycle pulse; frame0/fn0 latched this edge.
- req1, frame1, fn1, ack1: same as requester 0, for requester 1.
- flt_in_en  out  1  byte strobe to the filter.
- flt_iot_in  out  8  byte to the filter.
- flt_fn_sel  out  3  function select to the filter; held for the whole frame.
- flt_busy  in  1  filter stall request.
- flt_valid  in  1  filter result strobe.
- flt_iot_out  in  128  filter result.
- res_valid  out  1  one-cycle tagged-result strobe.
- res_src  out  1  source of the result (0/1).
- res_data  out  128  result data.
- err_orphan  out  1  sticky; flt_valid arrived with no outstanding tag.
- idle  out  1  high in IDLE with the tag FIFO empty.

Behaviour:
- Reset values:
  - ack0, ack1, flt_in_en, res_valid, err_orphan = 0.
  - flt_iot_in, flt_fn_sel, res_src, res_data = 0.
  - idle = 1; state = IDLE; tag FIFO empty; rr pointer = 1, so requester 0 wins the first tie.
  - Reset mid-stream aborts the frame immediately: flt_in_en drops asynchronously, tags are discarded, and the partial frame is not re-sent.
- FSM IDLE -> STREAM -> IDLE:
  - IDLE, entry condition: any req and tag FIFO not full.
    - Arbitration: one req high wins; if both are high, grant the requester != rr, then rr <= granted id.
    - Grant edge: latch frame/fn/id, pulse that requester's ack for 1 cycle, byte index <= 0, go to STREAM.
  - IDLE, otherwise: stay.
  - STREAM, byte output (registered outputs):
    - Each cycle with flt_busy=0: flt_in_en=1, flt_iot_in = latched byte[index], index++.
    - flt_busy=1: flt_in_en=0, index holds, byte not consumed.
  - STREAM, last byte: on the edge that sends byte NBYTES-1, push id to the tag FIFO and return to IDLE.
    - This gives a minimum 1-cycle gap (flt_in_en=0) between frames.
  - flt_fn_sel = latched fn from the grant until the next grant; it does not change mid-frame.
- Result path:
  - On flt_valid: pop the tag FIFO. Next cycle: res_valid=1, res_data = flt_iot_out, res_src = popped id.
  - flt_valid with the FIFO empty: no res_valid; err_orphan <= 1 until reset.
  - Push and pop in the same cycle: both happen; occupancy unchanged.
  - A full FIFO blocks new grants only; it never interrupts a frame already streaming.
- ack is never asserted for a requester whose req is low; a req drop before ack is legal and withdraws the request.
- Results are returned in grant order, because the filter is in-order.

Test Plan:
- Single frame:
  - Stimulus: req0 with frame0 = 0x80000000_00000000_00000000_00000000, fn0 = 3'b001.
  - Response: ack0 pulses once; 16 consecutive flt_in_en bytes 0x80 then 15×0x00; flt_fn_sel = 001 throughout.
  - Return: filter returns all-ones → res_valid with res_src = 0, res_data = 128'hFFFF…FFFF.
- Contention:
  - Stimulus: req0 and req1 both held high from reset.
  - Response: grants ordered 0,1,0,1; each ack is a single pulse.
  - Gap: exactly 1 idle cycle of flt_in_en between frames.
  - Tags: res_src sequence 0,1,0,1.
- Busy stall:
  - Stimulus: assert flt_busy for 3 cycles after byte 5 of frame 0x000102…0F.
  - Response: flt_in_en low for those 3 cycles; byte 0x06 follows 0x05 with no skip or repeat.
- Tag full:
  - Stimulus: TAG_DEPTH=4, filter never asserts flt_valid, req1 held high.
  - Response: exactly 4 acks, then req1 starves.
  - Release: one flt_valid → one res_valid (res_src = 1), followed by a fifth ack.
- Orphan:
  - Stimulus: flt_valid pulse with no frames sent.
  - Response: res_valid stays 0, err_orphan = 1 and stays 1 until rst.
- Reset mid-stream:
  - Stimulus: assert rst at byte 8.
  - Response: flt_in_en = 0 immediately, idle = 1 after release, FIFO empty.
  - Restart: the next req0 is granted from byte 0.
